// File: rtl/c1541_pkg.sv
// Shared D64 geometry helpers and FSM state type
// for the 1541 track buffer manager.
package c1541_pkg;

   localparam int MAX_SPT   = 21;
   localparam int RAM_DEPTH = MAX_SPT * 256;

   typedef enum logic [2:0] {
      S_NOIMG,
      S_IDLE,
      S_SETTLE,
      S_FLUSH_REQ,
      S_FLUSH_XFER,
      S_LOAD_REQ,
      S_LOAD_XFER
   } state_t;

   function automatic logic [4:0] spt(input logic [5:0] t);
      logic [4:0] r;
      r = 5'd17;
      unique case (1'b1)
         t <= 6'd17:                r = 5'd21;
         t >= 6'd18 && t <= 6'd24:  r = 5'd19;
         t >= 6'd25 && t <= 6'd30:  r = 5'd18;
         t >= 6'd31:                r = 5'd17;
      endcase
      return r;
   endfunction

   function automatic logic [9:0] track_lba(input logic [5:0] t);
      logic [9:0] n;
      logic [9:0] r;
      n = {4'd0, t};
      r = 10'd0;
      unique case (1'b1)
         n <= 10'd18:
            r = (n == 10'd0) ? 10'd0 : (n - 10'd1) * 10'd21;
         n >= 10'd19 && n <= 10'd25:
            r = 10'd357 + (n - 10'd18) * 10'd19;
         n >= 10'd26 && n <= 10'd31:
            r = 10'd490 + (n - 10'd25) * 10'd18;
         n >= 10'd32:
            r = 10'd598 + (n - 10'd31) * 10'd17;
      endcase
      return r;
   endfunction

   function automatic logic [4:0] lowest_set(
      input logic [MAX_SPT-1:0] v
   );
      logic [4:0] r;
      r = 5'd0;
      for (int i = MAX_SPT - 1; i >= 0; i--)
         if (v[i]) r = 5'(i);
      return r;
   endfunction

endpackage

// File: rtl/c1541_track_ram.sv
// True dual-port track buffer, 21 sectors x 256 bytes,
// registered read data on both ports.
module c1541_track_ram
   import c1541_pkg::*;
(
   input  logic        clk32,
   input  logic        reset_n,
   input  logic [12:0] a_addr,
   input  logic [7:0]  a_di,
   input  logic        a_we,
   output logic [7:0]  a_do,
   input  logic [12:0] b_addr,
   input  logic [7:0]  b_di,
   input  logic        b_we,
   output logic [7:0]  b_do
);

   logic [7:0] mem [0:RAM_DEPTH-1];

   always_ff @(posedge clk32) begin
      if (a_we && a_addr < 13'(RAM_DEPTH))
         mem[a_addr] <= a_di;
      if (b_we && b_addr < 13'(RAM_DEPTH))
         mem[b_addr] <= b_di;
   end

   always_ff @(posedge clk32 or negedge reset_n) begin
      if (!reset_n) begin
         a_do <= 8'd0;
         b_do <= 8'd0;
      end else begin
         a_do <= mem[a_addr];
         b_do <= mem[b_addr];
      end
   end

endmodule

// File: rtl/c1541_track_loader.sv
// Track buffer manager: flushes dirty sectors and loads
// the settled track between the GCR stage and the SD image.
module c1541_track_loader
   import c1541_pkg::*;
#(
   parameter int SETTLE_CYCLES = 32000
) (
   input  logic        clk32,
   input  logic        reset_n,
   input  logic        img_mounted,
   input  logic        img_readonly,
   input  logic [5:0]  track,
   input  logic [4:0]  sector,
   input  logic [7:0]  byte_addr,
   output logic [7:0]  ram_do,
   input  logic [7:0]  ram_di,
   input  logic        ram_we,
   output logic        ram_ready,
   output logic        busy,
   output logic [31:0] sd_lba,
   output logic        sd_rd,
   output logic        sd_wr,
   input  logic        sd_ack,
   input  logic [7:0]  sd_buff_addr,
   input  logic [7:0]  sd_buff_dout,
   output logic [7:0]  sd_buff_din,
   input  logic        sd_buff_wr
);

   state_t             state;
   logic [5:0]         trk;
   logic [5:0]         cur;
   logic [5:0]         tgt;
   logic [4:0]         s;
   logic [9:0]         lba_q;
   logic [31:0]        cnt;
   logic               mount_pend;
   logic [MAX_SPT-1:0] dirty;
   logic [MAX_SPT-1:0] s_mask;
   logic [MAX_SPT-1:0] flush_vec;
   logic [4:0]         pick;
   logic [9:0]         pick_lba;
   logic               last;
   logic               a_we;
   logic               b_we;

   assign trk    = (track == 6'd0) ? 6'd1 : track;
   assign sd_lba = {22'd0, lba_q};

   // In FLUSH_XFER the sector in flight is excluded
   // so the next pick is ready on the same edge.
   assign s_mask = {{(MAX_SPT-1){1'b0}}, 1'b1} << s;
   assign flush_vec = (state == S_FLUSH_XFER) ?
                      (dirty & ~s_mask) : dirty;
   assign pick     = lowest_set(flush_vec);
   assign pick_lba = track_lba(cur) + {5'd0, pick};
   assign last     = (s == spt(tgt) - 5'd1);

   assign a_we = ram_we & ram_ready;
   assign b_we = sd_ack & sd_buff_wr &
                 (state == S_LOAD_REQ ||
                  state == S_LOAD_XFER);

   c1541_track_ram u_ram (
      .clk32   (clk32),
      .reset_n (reset_n),
      .a_addr  ({sector, byte_addr}),
      .a_di    (ram_di),
      .a_we    (a_we),
      .a_do    (ram_do),
      .b_addr  ({s, sd_buff_addr}),
      .b_di    (sd_buff_dout),
      .b_we    (b_we),
      .b_do    (sd_buff_din)
   );

   always_ff @(posedge clk32 or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_NOIMG;
         cur        <= 6'd1;
         tgt        <= 6'd1;
         s          <= 5'd0;
         lba_q      <= 10'd0;
         cnt        <= 32'd0;
         mount_pend <= 1'b0;
         dirty      <= '0;
         ram_ready  <= 1'b0;
         busy       <= 1'b0;
         sd_rd      <= 1'b0;
         sd_wr      <= 1'b0;
      end else if (img_mounted) begin
         state      <= S_NOIMG;
         mount_pend <= 1'b1;
         dirty      <= '0;
         ram_ready  <= 1'b0;
         busy       <= 1'b0;
         sd_rd      <= 1'b0;
         sd_wr      <= 1'b0;
      end else begin
         if (ram_ready && ram_we && sector < spt(cur))
            dirty[sector] <= 1'b1;
         unique case (state)
            S_NOIMG:
               if (mount_pend && !sd_ack) begin
                  mount_pend <= 1'b0;
                  tgt        <= trk;
                  s          <= 5'd0;
                  lba_q      <= track_lba(trk);
                  sd_rd      <= 1'b1;
                  busy       <= 1'b1;
                  state      <= S_LOAD_REQ;
               end
            S_IDLE:
               if (trk != cur) begin
                  ram_ready <= 1'b0;
                  tgt       <= trk;
                  cnt       <= 32'd0;
                  state     <= S_SETTLE;
               end
            S_SETTLE:
               if (trk != tgt) begin
                  tgt <= trk;
                  cnt <= 32'd0;
               end else if (cnt == 32'(SETTLE_CYCLES - 1)) begin
                  busy <= 1'b1;
                  if (img_readonly || dirty == '0) begin
                     s     <= 5'd0;
                     lba_q <= track_lba(tgt);
                     sd_rd <= 1'b1;
                     state <= S_LOAD_REQ;
                  end else begin
                     s     <= pick;
                     lba_q <= pick_lba;
                     sd_wr <= 1'b1;
                     state <= S_FLUSH_REQ;
                  end
               end else begin
                  cnt <= cnt + 32'd1;
               end
            S_FLUSH_REQ:
               if (sd_ack) begin
                  sd_wr <= 1'b0;
                  state <= S_FLUSH_XFER;
               end
            S_FLUSH_XFER:
               if (!sd_ack) begin
                  dirty[s] <= 1'b0;
                  if (flush_vec != '0) begin
                     s     <= pick;
                     lba_q <= pick_lba;
                     sd_wr <= 1'b1;
                     state <= S_FLUSH_REQ;
                  end else begin
                     s     <= 5'd0;
                     lba_q <= track_lba(tgt);
                     sd_rd <= 1'b1;
                     state <= S_LOAD_REQ;
                  end
               end
            S_LOAD_REQ:
               if (sd_ack) begin
                  sd_rd <= 1'b0;
                  state <= S_LOAD_XFER;
               end
            S_LOAD_XFER:
               if (!sd_ack) begin
                  if (last) begin
                     cur       <= tgt;
                     dirty     <= '0;
                     ram_ready <= 1'b1;
                     busy      <= 1'b0;
                     state     <= S_IDLE;
                  end else begin
                     s     <= s + 5'd1;
                     lba_q <= lba_q + 10'd1;
                     sd_rd <= 1'b1;
                     state <= S_LOAD_REQ;
                  end
               end
            default: state <= S_NOIMG;
         endcase
      end
   end

endmodule
